jk_bank_arbiter: RTL and testbench

Shared-access controller for a bank of JK flip-flops, each built as a D flip-flop with J/K next-state logic. Up to NREQ requesters post single-bit JK commands (hold/reset/set/toggle) against a WIDTH-bit JK register bank. The block arbitrates round-robin, sequences each command through a three-state FSM and returns a one-cycle grant. It sits between control agents and the JK storage they share, so no two agents ever drive J/K of the bank in the same cycle.

---
 rtl/jk_bank_arbiter.sv | 167 ++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Arbitrated IDLE/APPLY/DONE access to a shared JK flip-flop bank, one command per three clocks.
// Define JK_ARB_FIXED_PRIO_EN to select fixed lowest-index priority instead of round-robin.
module jk_bank_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [2*NREQ-1:0]        op,
   input  logic [ADDR_W*NREQ-1:0]   addr,
   output logic [NREQ-1:0]          gnt,
   output logic                     err,
   output logic                     busy,
   output logic [WIDTH-1:0]         q
);

   localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]    q_q, q_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic [ID_W-1:0]     win_c;
   logic                any_c;
   logic [WIDTH-1:0]    j_c, k_c;

`ifdef JK_ARB_FIXED_PRIO_EN
   // Lowest-indexed requester wins; downward scan leaves the lowest hit.
   always_comb begin
      win_c = '0;
      any_c = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_c = ID_W'(i);
            any_c = 1'b1;
         end
      end
   end
`else
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     idx_c;

   // First high req at or after rr_ptr, scanning upward modulo NREQ.
   always_comb begin
      win_c = '0;
      any_c = 1'b0;
      idx_c = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx_c = ID_W'((32'(rr_ptr_q) + 32'(k)) % NREQ);
         if (req[idx_c]) begin
            win_c = idx_c;
            any_c = 1'b1;
         end
      end
   end
`endif

   // J/K drive: only the latched bit sees the command, and only in APPLY.
   always_comb begin
      j_c = '0;
      k_c = '0;
      if (state_q == APPLY) begin
         for (int unsigned b = 0; b < WIDTH; b++) begin
            if (32'(addr_q) == b) begin
               j_c[b] = op_q[1];
               k_c[b] = op_q[0];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      op_d    = op_q;
      addr_d  = addr_q;
      q_d     = q_q;
      gnt_d   = '0;
      err_d   = err_q;
      busy_d  = busy_q;
`ifndef JK_ARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_c) begin
               id_d = win_c;
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (32'(win_c) == i) begin
                     op_d   = op[2*i +: 2];
                     addr_d = addr[ADDR_W*i +: ADDR_W];
                  end
               end
               busy_d  = 1'b1;
               state_d = APPLY;
            end
         end
         APPLY: begin
            q_d   = (j_c & ~q_q) | (~k_c & q_q);
            err_d = (32'(addr_q) >= WIDTH);
            for (int unsigned i = 0; i < NREQ; i++) begin
               gnt_d[i] = (32'(id_q) == i);
            end
            state_d = DONE;
         end
         DONE: begin
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
`ifndef JK_ARB_FIXED_PRIO_EN
            rr_ptr_d = ID_W'((32'(id_q) + 32'd1) % NREQ);
`endif
         end
         default: begin
            busy_d  = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         id_q     <= '0;
         op_q     <= '0;
         addr_q   <= '0;
         q_q      <= '0;
         gnt_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifndef JK_ARB_FIXED_PRIO_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         q_q      <= q_d;
         gnt_q    <= gnt_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
`ifndef JK_ARB_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign err  = err_q;
   assign busy = busy_q;
   assign q    = q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: latency, JK ops, arbitration order, range error, async reset.
module tb_jk_bank_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [15:0] addr;
   logic [3:0]  gnt;
   logic        err;
   logic        busy;
   logic [7:0]  q;

   int checks;
   int failures;

   jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .ADDR_W(4)) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .op   (op),
      .addr (addr),
      .gnt  (gnt),
      .err  (err),
      .busy (busy),
      .q    (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      op    = '0;
      addr  = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      req      = '0;
      op       = '0;
      addr     = '0;
      @(negedge clk);
      #1;
      check("rst_q", 32'(q), 32'h00);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      do_reset();

      // Requester 0 sets bit 3.
      req = 4'b0001; op = 8'b0000_0010; addr = 16'h0003;
      step();
      check("set3_e0_busy", 32'(busy), 32'h1);
      check("set3_e0_gnt", 32'(gnt), 32'h0);
      check("set3_e0_q", 32'(q), 32'h00);
      step();
      check("set3_e1_q", 32'(q), 32'h08);
      check("set3_e1_gnt", 32'(gnt), 32'h1);
      check("set3_e1_err", 32'(err), 32'h0);
      check("set3_e1_busy", 32'(busy), 32'h1);
      req = '0;
      step();
      check("set3_e2_gnt", 32'(gnt), 32'h0);
      check("set3_e2_busy", 32'(busy), 32'h0);

      // Requester 1 toggles bit 7 twice, req held throughout.
      do_reset();
      req = 4'b0010; op = 8'b0000_1100; addr = 16'h0070;
      step();
      step();
      check("tog_first_gnt", 32'(gnt), 32'h2);
      check("tog_first_q", 32'(q), 32'h80);
      step();
      check("tog_gap1_gnt", 32'(gnt), 32'h0);
      step();
      check("tog_gap2_gnt", 32'(gnt), 32'h0);
      step();
      check("tog_second_gnt", 32'(gnt), 32'h2);
      check("tog_second_q", 32'(q), 32'h00);
      req = '0;
      step();
      step();

      // All four set their own bit; each drops req once granted.
      do_reset();
      req = 4'b1111; op = 8'b1010_1010; addr = 16'h3210;
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("all_gnt%0d", k), 32'(gnt), 32'(4'b0001 << k));
         req[k] = 1'b0;
         step();
         step();
      end
      check("all_final_q", 32'(q), 32'h0F);
      check("all_idle_busy", 32'(busy), 32'h0);

      // Out-of-range toggle from requester 2.
      do_reset();
      req = 4'b0100; op = 8'b0011_0000; addr = 16'h0900;
      step();
      step();
      check("oor_gnt", 32'(gnt), 32'h4);
      check("oor_err", 32'(err), 32'h1);
      check("oor_q", 32'(q), 32'h00);
      req = '0;
      step();
      check("oor_err_clear", 32'(err), 32'h0);
      check("oor_gnt_clear", 32'(gnt), 32'h0);

      // Reset in APPLY clears q immediately; first grant afterwards goes to 0.
      do_reset();
      req = 4'b0010; op = 8'b0000_1000; addr = 16'h0060;
      step();
      step();
      check("pre_q", 32'(q), 32'h40);
      req = '0;
      step();
      req = 4'b1111; op = 8'b1010_1010; addr = 16'h5555;
      step();
      check("mid_busy", 32'(busy), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_q", 32'(q), 32'h00);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("post_rst_nognt", 32'(gnt), 32'h0);
      step();
      check("post_rst_gnt", 32'(gnt), 32'h1);
      check("post_rst_q", 32'(q), 32'h20);
      req = '0;
      step();
      step();

      // Requesters 0 and 1 held continuously: rotation vs fixed priority.
      do_reset();
      req = 4'b0011; op = 8'b0000_1010; addr = 16'h0010;
      step();
      for (int k = 0; k < 3; k++) begin
         step();
`ifdef JK_ARB_FIXED_PRIO_EN
         check($sformatf("hold_gnt%0d", k), 32'(gnt), 32'h1);
`else
         check($sformatf("hold_gnt%0d", k), 32'(gnt), (k == 1) ? 32'h2 : 32'h1);
`endif
         step();
         step();
      end
      req = '0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
